// File: rtl/sumador_pkg.sv
// Shared types and constants for the sequential nibble adder.
package sumador_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Step counter width: at least one bit, even when only one nibble step exists.
    function automatic int cnt_width(input int width);
        int n;
        n = width / NIBBLE;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sumador_nibble.sv
// 4-bit combinational ripple-carry stage, shared across all nibble steps.
module sumador_nibble
    import sumador_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] sum,
    output logic              cout
);

    logic [NIBBLE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIBBLE];
    end

endmodule

// File: rtl/sumador_secuencial.sv
// Sequential WIDTH-bit adder: one shared nibble stage, LSB nibble first.
// Define SUMADOR_OVERFLOW_EN to add the registered signed-overflow output ovf.
module sumador_secuencial
    import sumador_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SUMADOR_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < NIBBLE || (WIDTH % NIBBLE) != 0) begin : g_bad_width
            $error("sumador_secuencial: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_sr, b_sr, sum_r, sum_shift;
    logic              carry, cout_r;
    logic [NIBBLE-1:0] nib_sum;
    logic              nib_cout;
    logic              last_step;

    sumador_nibble u_nibble (
        .a    (a_sr[NIBBLE-1:0]),
        .b    (b_sr[NIBBLE-1:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // New nibble enters from the top so after N steps nibble 0 sits at the bottom.
    generate
        if (N == 1) begin : g_one
            assign sum_shift = nib_sum;
        end else begin : g_many
            assign sum_shift = {nib_sum, sum_r[WIDTH-1:NIBBLE]};
        end
    endgenerate

    assign last_step = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_nx = RUN;
            end
            RUN:  if (cnt == LAST) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sr  <= in_a;
                    b_sr  <= in_b;
                    carry <= cin;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sr  <= a_sr >> NIBBLE;
                    b_sr  <= b_sr >> NIBBLE;
                    sum_r <= sum_shift;
                    carry <= nib_cout;
                    cnt   <= cnt + 1'b1;
                    if (last_step) cout_r <= nib_cout;
                end
                default: ;
            endcase
        end
    end

    // Outputs are masked outside DONE so a partially shifted sum never shows.
    assign sum  = out_valid ? sum_r  : '0;
    assign cout = out_valid ? cout_r : 1'b0;

`ifdef SUMADOR_OVERFLOW_EN
    logic ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_r <= 1'b0;
        else if (last_step)
            ovf_r <= (a_sr[NIBBLE-1] == b_sr[NIBBLE-1]) && (nib_sum[NIBBLE-1] != a_sr[NIBBLE-1]);
    end

    assign ovf = out_valid ? ovf_r : 1'b0;
`endif

endmodule

// File: tb/tb_sumador_secuencial.sv
// Randomized bench for sumador_secuencial against an arithmetic reference model.
module tb_sumador_secuencial;

    localparam int W = 16;
    localparam int N = W / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;

    logic       v4 = 1'b0, c4 = 1'b0, or4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ir4, ov4, co4, ovf4;
    logic [3:0] s4;

    sumador_secuencial #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SUMADOR_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    sumador_secuencial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4),
        .in_a(a4), .in_b(b4), .cin(c4), .out_valid(ov4),
        .out_ready(or4), .sum(s4), .cout(co4)
`ifdef SUMADOR_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );

`ifndef SUMADOR_OVERFLOW_EN
    assign ovf  = 1'b0;
    assign ovf4 = 1'b0;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic ovf_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
    endfunction

    // Reference model: one outstanding operation, result visible N edges after accept.
    logic         pending = 1'b0;
    int           t_acc = 0;
    logic [W:0]   exp_res = '0;
    logic         exp_ovf = 1'b0;

    function automatic logic exp_valid();
        return pending && ((cyc - t_acc) >= N);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (!pending) begin
            if (in_valid) begin
                pending <= 1'b1;
                t_acc   <= cyc + 1;
                exp_res <= {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, cin};
                exp_ovf <= ovf_of(in_a, in_b, cin);
            end
        end else if (exp_valid() && out_ready) begin
            pending <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, exp_valid());
            chk("in_ready", in_ready, !pending);
            if (exp_valid()) begin
                chk("sum", sum, exp_res[W-1:0]);
                chk("cout", cout, exp_res[W]);
`ifdef SUMADOR_OVERFLOW_EN
                chk("ovf", ovf, exp_ovf);
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int hold, input bit noise,
                          output logic [W-1:0] s, output logic co, output logic ov, output int lat);
        int k, acc;
        s = '0; co = 1'b0; ov = 1'b0; lat = -1;
        k = 0;
        while (!in_ready && k < 40) begin @(negedge clk); k++; end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        in_a = a; in_b = b; cin = c; in_valid = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = W'($urandom); in_b = W'($urandom); cin = 1'($urandom);
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        if (!out_valid) chk("result_timeout", out_valid, 1);
        lat = cyc - acc + 1;
        s = sum; co = cout; ov = ovf;
        repeat (hold) begin
            if (noise) begin
                in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] s;
        logic co, ov;
        int lat;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, s, co, ov, lat);
        chk("lit_1234_sum", s, 32'h5555);
        chk("lit_1234_cout", co, 0);
        chk("lit_1234_ovf", ov, 0);
        chk("lit_latency16", lat, 5);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0, s, co, ov, lat);
        chk("lit_ffff_sum", s, 32'h0000);
        chk("lit_ffff_cout", co, 1);

        run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0, s, co, ov, lat);
        chk("lit_cin_sum", s, 32'h0001);
        chk("lit_cin_cout", co, 0);

        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, s, co, ov, lat);
        chk("lit_7fff_sum", s, 32'h8000);
        chk("lit_7fff_cout", co, 0);
`ifdef SUMADOR_OVERFLOW_EN
        chk("lit_7fff_ovf", ov, 1);
`endif

        // Backpressure with operand noise during RUN and DONE.
        run_op(16'h00FF, 16'h0F01, 1'b1, 3, 1'b1, s, co, ov, lat);
        chk("lit_bp_sum", s, 32'h1001);
        chk("lit_bp_cout", co, 0);

        // Asynchronous reset in the middle of a run.
        in_a = 16'hFFFF; in_b = 16'hFFFF; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h0003, 16'h0004, 1'b0, 0, 1'b0, s, co, ov, lat);
        chk("lit_after_rst_sum", s, 32'h0007);
        chk("lit_after_rst_cout", co, 0);

        for (int i = 0; i < 25; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), s, co, ov, lat);
        end

        // Narrow instance: single RUN cycle.
        @(negedge clk);
        chk("w4_in_ready", ir4, 1);
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b1; v4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        chk("w4_valid_cycle1", ov4, 0);
        @(negedge clk);
        chk("w4_valid_cycle2", ov4, 1);
        chk("w4_sum", s4, 32'h1);
        chk("w4_cout", co4, 1);
        chk("w4_ovf", ovf4, 0);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk("w4_valid_drop", ov4, 0);
        chk("w4_ready_back", ir4, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sumador_secuencial.md
# sumador_secuencial

Sequential multi-nibble adder controller: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then sequences a single shared 4-bit ripple-carry stage over the operands, least-significant nibble first. Between nibbles the carry is held in a register. Trades latency for area wherever wide additions are infrequent. It is the next step up from the combinational 4-bit adder: the same datapath, now time-multiplexed under a small FSM.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4 (elaboration error otherwise)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands on in_a/in_b/cin are valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- in_a  in  WIDTH  first operand
- in_b  in  WIDTH  second operand
- cin  in  1  carry-in to nibble 0
- out_valid  out  1  result on sum/cout (and ovf) is valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB
- ovf  out  1  signed overflow (only with SUMADOR_OVERFLOW_EN)

## Operation
- N = WIDTH/4 nibble steps; step counter width max(1, $clog2(N)).
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch in_a, in_b into shift registers, cin into carry register, clear counter, go RUN.
- RUN: nibble adder gets the low nibbles of the A/B shift registers plus the carry register. Each cycle:
  - its 4-bit sum shifts into the sum register from the top (right shift by 4);
  - its carry-out is written to the carry register;
  - A/B shift right by 4 and the counter increments.
- RUN exit: on step N-1, latch the final carry into cout and go DONE.
- DONE: out_valid=1; sum/cout/ovf held stable. On out_ready, go IDLE.
- in_ready=0 in RUN and DONE; in_valid is ignored there. No back-to-back accept from DONE.
- Arithmetic: {cout,sum} = in_a + in_b + cin, unsigned modulo 2^(WIDTH+1).
- Reset values: in_ready=0 while rst_n low, 1 in IDLE after release; out_valid=0, sum=0, cout=0, ovf=0; state=IDLE; counter/carry/shift registers=0.
- Reset asserted mid-RUN or in DONE: operation discarded, all outputs return to reset values immediately (asynchronous). No partial result is ever presented.

## Timing
- Accept edge = cycle 0 (in_valid && in_ready sampled high).
- RUN occupies cycles 1..N; out_valid rises after the edge ending cycle N (WIDTH=16: out_valid high from cycle 5).
- Latency accept→out_valid: N+1 cycles. Minimum issue interval: N+2 cycles (includes one IDLE cycle).
- out_valid and result stay stable under backpressure until the out_ready edge.
- out_valid falls on the cycle after the handshake; in_ready rises on the same edge.
- WIDTH=4: single RUN cycle, latency 2.

## Configuration
- SUMADOR_OVERFLOW_EN defined:
  - ovf port present;
  - on the final RUN step, ovf = (a_msb == b_msb) && (sum_msb != a_msb), using the top-nibble bits in the shift registers and the nibble sum;
  - ovf is registered alongside cout and reset to 0.
- SUMADOR_OVERFLOW_EN undefined: ovf port and its logic absent; all other behaviour identical.

## Structure
- Package sumador_pkg:
  - state enum (IDLE, RUN, DONE);
  - NIBBLE=4 constant;
  - function for counter width from WIDTH.
- Sub-module sumador_nibble: 4-bit combinational ripple-carry stage (a[3:0], b[3:0], cin → sum[3:0], cout), instantiated once.
- The controller holds the FSM, counter, shift registers and carry register.

## Test plan
- WIDTH=16, 0x1234 + 0x4321, cin=0 → sum=0x5555, cout=0, ovf=0; out_valid first high 5 cycles after accept.
- 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1 (carry ripples through all 4 steps via register).
- 0x0000 + 0x0000, cin=1 → sum=0x0001, cout=0; 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1 (with macro).
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, pulse in_valid with new operands during RUN and DONE → result unchanged and stable, new operands ignored, in_ready=0 throughout; accepted only after return to IDLE.
- Assert rst_n low during RUN step 2 of 0xFFFF + 0xFFFF → out_valid, sum, cout immediately 0; after release, 0x0003 + 0x0004 yields 0x0007 with no residue.
- WIDTH=4 instance: 0xF + 0x1, cin=1 → sum=0x1, cout=1, latency 2.
